// File: rtl/usb_rx_bit_recovery.sv
// USB full-speed receive front end: line synchronizer, bit-timing recovery, NRZI
// decode, bit unstuffing and EOP detection feeding an 8-bit receive shift register.
module usb_rx_bit_recovery #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int STUFF_RUN    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_enable,
    input  logic d_plus,
    input  logic d_minus,
    output logic d_original,
    output logic shift_enable,
    output logic byte_done,
    output logic eop,
    output logic stuff_err
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_RUN + 1);
    localparam logic [TW-1:0] PHASE = TW'(SAMPLE_PHASE);
    localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] RUN   = OW'(STUFF_RUN);

    typedef enum logic [1:0] {IDLE, RECEIVE, EOP_WAIT} state_t;

    state_t        state_q, state_d;
    logic          dp_meta, dp_sync, dp_last, dm_meta, dm_sync;
    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          prev_dp_q, prev_dp_d;
    logic          shift_d, dout_d, eop_d, stuff_d, wrap_d;
    logic [1:0]    done_pipe;
    logic          line_edge, fall, sample, se0, line_j, decoded;

    // Lines reset to idle J so leaving reset never looks like a SYNC edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_last <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
        end else begin
            dp_meta <= d_plus;
            dp_sync <= dp_meta;
            dp_last <= dp_sync;
            dm_meta <= d_minus;
            dm_sync <= dm_meta;
        end
    end

    assign line_edge = dp_sync ^ dp_last;
    assign fall      = dp_last & ~dp_sync;
    assign se0       = ~dp_sync & ~dm_sync;
    assign line_j    = dp_sync & ~dm_sync;
    assign decoded   = (dp_sync == prev_dp_q);
    // An edge re-phases the timer and suppresses a coincident sample.
    assign sample    = (state_q != IDLE) && !line_edge && (timer_q == PHASE);

    always_comb begin
        state_d   = state_q;
        timer_d   = (line_edge || timer_q == T_MAX) ? '0 : timer_q + TW'(1);
        ones_d    = ones_q;
        bit_cnt_d = bit_cnt_q;
        prev_dp_d = prev_dp_q;
        shift_d   = 1'b0;
        dout_d    = d_original;
        eop_d     = 1'b0;
        stuff_d   = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                ones_d    = '0;
                bit_cnt_d = '0;
                prev_dp_d = 1'b1;
                if (fall && rx_enable) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (sample) begin
                    if (se0) begin
                        eop_d     = 1'b1;
                        ones_d    = '0;
                        bit_cnt_d = '0;
                        prev_dp_d = 1'b1;
                        state_d   = EOP_WAIT;
                    end else begin
                        prev_dp_d = dp_sync;
                        if (ones_q == RUN) begin
                            ones_d  = '0;
                            stuff_d = decoded;
                        end else begin
                            shift_d   = 1'b1;
                            dout_d    = decoded;
                            ones_d    = decoded ? ones_q + OW'(1) : '0;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            wrap_d    = (bit_cnt_q == 3'd7);
                        end
                    end
                end
            end
            EOP_WAIT: begin
                if (sample) begin
                    prev_dp_d = 1'b1;
                    if (line_j) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rx_enable) begin
            state_d = IDLE;
            shift_d = 1'b0;
            eop_d   = 1'b0;
            stuff_d = 1'b0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ones_q    <= '0;
            bit_cnt_q <= '0;
            prev_dp_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ones_q    <= ones_d;
            bit_cnt_q <= bit_cnt_d;
            prev_dp_q <= prev_dp_d;
        end
    end

    // byte_done trails the 8th shift strobe by one cycle so the shift register is settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_enable <= 1'b0;
            d_original   <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
            done_pipe    <= '0;
        end else begin
            shift_enable <= shift_d;
            d_original   <= dout_d;
            eop          <= eop_d;
            stuff_err    <= stuff_d;
            done_pipe    <= {done_pipe[0] & rx_enable, wrap_d};
        end
    end

    assign byte_done = done_pipe[1];
endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Self-checking bench: packets are NRZI/bit-stuff encoded into line symbols and the
// observed strobes are compared against a symbol-level decode model.
module tb_usb_rx_bit_recovery;
    localparam int CPB   = 8;
    localparam int PHASE = 3;
    localparam int RUN   = 6;
    localparam int LAT   = 2 + 1 + PHASE + 1;  // sync, timer re-phase, phase count, output flop
    localparam int SE0 = 0, SJ = 1, SK = 2;
    localparam logic [1:0] K_SHIFT = 2'd0, K_BD = 2'd1, K_EOP = 2'd2, K_ERR = 2'd3;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic        val;
    } ev_t;

    logic clk, rst, rx_enable, d_plus, d_minus;
    logic d_original, shift_enable, byte_done, eop, stuff_err;

    int   cyc = 0;
    int   vectors = 0, miscompares = 0, excl_viol = 0;
    int   sym_q[$], hold_q[$], st_q[$];
    int   data_end;
    logic [7:0] data_q[$];
    ev_t  got_q[$], exp_q[$];

    usb_rx_bit_recovery #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(PHASE), .STUFF_RUN(RUN)) dut (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .d_plus(d_plus), .d_minus(d_minus),
        .d_original(d_original), .shift_enable(shift_enable), .byte_done(byte_done),
        .eop(eop), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [1:0] k, input logic v);
        mk = {32'(c), k, v};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (shift_enable) got_q.push_back(mk(cyc, K_SHIFT, d_original));
            if (byte_done)    got_q.push_back(mk(cyc, K_BD, 1'b0));
            if (eop)          got_q.push_back(mk(cyc, K_EOP, 1'b0));
            if (stuff_err)    got_q.push_back(mk(cyc, K_ERR, 1'b0));
            if (int'(shift_enable) + int'(eop) + int'(stuff_err) > 1) excl_viol++;
        end
    end

    function automatic int count_kind(input logic [1:0] k);
        int n = 0;
        foreach (got_q[i]) if (got_q[i].kind == k) n++;
        return n;
    endfunction

    // SYNC + data (LSB first), optional stuffing after RUN ones, NRZI from idle J, then EOP.
    task automatic make_packet(input int nbytes, input bit stuff, input bit append);
        bit b[$];
        int ones = 0;
        bit lvl = 1'b1;
        logic [7:0] byt;
        if (!append) begin sym_q.delete(); hold_q.delete(); end
        repeat (2) begin sym_q.push_back(SJ); hold_q.push_back(CPB); end
        repeat (7) b.push_back(1'b0);
        b.push_back(1'b1);
        for (int n = 0; n < nbytes; n++) begin
            byt = data_q[n];
            for (int i = 0; i < 8; i++) b.push_back(byt[i]);
        end
        foreach (b[i]) begin
            if (!b[i]) lvl = ~lvl;
            sym_q.push_back(lvl ? SJ : SK); hold_q.push_back(CPB);
            if (stuff) begin
                ones = b[i] ? ones + 1 : 0;
                if (ones == RUN) begin
                    lvl = ~lvl;
                    sym_q.push_back(lvl ? SJ : SK); hold_q.push_back(CPB);
                    ones = 0;
                end
            end
        end
        data_end = sym_q.size();
        foreach (b[i]) if (i < 5) begin
            sym_q.push_back(i < 2 ? SE0 : SJ); hold_q.push_back(CPB);
        end
    endtask

    task automatic drive_seq(input int count);
        st_q.delete();
        @(posedge clk); #2;
        for (int i = 0; i < count; i++) begin
            d_plus  = (sym_q[i] == SJ);
            d_minus = (sym_q[i] == SK);
            st_q.push_back(cyc);
            repeat (hold_q[i]) begin @(posedge clk); #2; end
        end
        d_plus = 1'b1; d_minus = 0;
        repeat (16) @(posedge clk);
        #2;
    endtask

    // Symbol-level decode: sample time follows the last D+ transition, NRZI/unstuff by rule.
    function automatic void run_model();
        int mode = 0, ones = 0, nb = 0, out = 0;
        bit prev = 1'b1, last = 1'b1, dp, dec, edge_s;
        exp_q.delete();
        for (int i = 0; i < st_q.size(); i++) begin
            dp = (sym_q[i] == SJ);
            edge_s = (dp != last);
            last = dp;
            if (mode == 0) begin
                if (!(edge_s && !dp)) continue;
                mode = 1; ones = 0; nb = 0; prev = 1'b1; out = st_q[i] + LAT;
            end else begin
                out = edge_s ? st_q[i] + LAT : out + CPB;
            end
            if (mode == 1) begin
                if (sym_q[i] == SE0) begin
                    exp_q.push_back(mk(out, K_EOP, 1'b0));
                    ones = 0; nb = 0; prev = 1'b1; mode = 2;
                end else begin
                    dec = (dp == prev);
                    prev = dp;
                    if (ones == RUN) begin
                        ones = 0;
                        if (dec) exp_q.push_back(mk(out, K_ERR, 1'b0));
                    end else begin
                        exp_q.push_back(mk(out, K_SHIFT, dec));
                        ones = dec ? ones + 1 : 0;
                        nb = (nb + 1) % 8;
                        if (nb == 0) exp_q.push_back(mk(out + 1, K_BD, 1'b0));
                    end
                end
            end else if (sym_q[i] == SJ) begin
                mode = 0;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_enable = 1'b1; d_plus = 1'b1; d_minus = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if ({d_original, shift_enable, byte_done, eop, stuff_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {d_original, shift_enable, byte_done, eop, stuff_err});
        end
        rst = 1'b0;
        got_q.delete();
        repeat (100) @(posedge clk);
        #2;
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL idle_pulses: got %0d pulses expected 0", got_q.size());
        end
    endtask

    task automatic test_sync();
        ev_t sh[$];
        int bd_cyc = -1;
        data_q.delete();
        make_packet(0, 1'b1, 1'b0);
        got_q.delete();
        drive_seq(sym_q.size());
        run_model();
        foreach (got_q[i]) begin
            if (got_q[i].kind == K_SHIFT) sh.push_back(got_q[i]);
            if (got_q[i].kind == K_BD) bd_cyc = int'(got_q[i].cyc);
        end
        vectors++;
        if (sh.size() !== 8) begin
            miscompares++;
            $display("FAIL sync_shift_count: got %0d expected 8", sh.size());
        end
        for (int i = 0; i < sh.size() && i < 8; i++) begin
            vectors++;
            if (sh[i].val !== logic'(i == 7)) begin
                miscompares++;
                $display("FAIL sync_bit%0d: got %0d expected %0d", i, sh[i].val, i == 7);
            end
            if (i > 0 && (sh[i].cyc - sh[i-1].cyc) !== 32'd8) begin
                miscompares++;
                $display("FAIL sync_spacing%0d: got %0d expected 8", i, sh[i].cyc - sh[i-1].cyc);
            end
        end
        if (sh.size() >= 8) begin
            vectors++;
            if (bd_cyc !== int'(sh[7].cyc) + 1) begin
                miscompares++;
                $display("FAIL sync_byte_done: got cycle %0d expected %0d", bd_cyc, sh[7].cyc + 1);
            end
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL sync_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL sync_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_stuffing();
        ev_t sh[$];
        data_q.delete();
        data_q.push_back(8'hFF);
        make_packet(1, 1'b1, 1'b0);
        got_q.delete();
        drive_seq(sym_q.size());
        run_model();
        foreach (got_q[i]) if (got_q[i].kind == K_SHIFT) sh.push_back(got_q[i]);
        vectors++;
        if (sh.size() !== 16 || count_kind(K_ERR) !== 0 || count_kind(K_BD) !== 2) begin
            miscompares++;
            $display("FAIL stuff_counts: got shifts=%0d errs=%0d bytes=%0d expected 16 0 2",
                     sh.size(), count_kind(K_ERR), count_kind(K_BD));
        end
        for (int i = 8; i < sh.size(); i++) begin
            vectors++;
            if (sh[i].val !== 1'b1) begin
                miscompares++;
                $display("FAIL stuff_bit%0d: got %0d expected 1", i, sh[i].val);
            end
        end
        if (sh.size() >= 14) begin
            vectors++;
            if ((sh[13].cyc - sh[12].cyc) !== 32'd16) begin
                miscompares++;
                $display("FAIL stuff_slot_gap: got %0d expected 16", sh[13].cyc - sh[12].cyc);
            end
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL stuff_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stuff_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_stuff_err();
        int last_sh = -1, err_cyc = -1;
        data_q.delete();
        data_q.push_back(8'hFE);  // a 0 then seven 1s, sent without stuffing
        make_packet(1, 1'b0, 1'b0);
        got_q.delete();
        drive_seq(sym_q.size());
        run_model();
        foreach (got_q[i]) begin
            if (got_q[i].kind == K_SHIFT && err_cyc < 0) last_sh = int'(got_q[i].cyc);
            if (got_q[i].kind == K_ERR) err_cyc = int'(got_q[i].cyc);
        end
        vectors++;
        if (count_kind(K_SHIFT) !== 15 || count_kind(K_ERR) !== 1) begin
            miscompares++;
            $display("FAIL stuff_err_counts: got shifts=%0d errs=%0d expected 15 1",
                     count_kind(K_SHIFT), count_kind(K_ERR));
        end
        vectors++;
        if (err_cyc !== last_sh + 8) begin
            miscompares++;
            $display("FAIL stuff_err_time: got %0d expected %0d", err_cyc, last_sh + 8);
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL stuff_err_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stuff_err_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_back_to_back();
        data_q.delete();
        data_q.push_back(8'($urandom));
        make_packet(1, 1'b1, 1'b0);
        data_q.delete();
        data_q.push_back(8'($urandom));
        make_packet(1, 1'b1, 1'b1);
        got_q.delete();
        drive_seq(sym_q.size());
        run_model();
        vectors++;
        if (count_kind(K_EOP) !== 2 || count_kind(K_BD) !== 4) begin
            miscompares++;
            $display("FAIL eop_counts: got eops=%0d bytes=%0d expected 2 4", count_kind(K_EOP), count_kind(K_BD));
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_jitter();
        int j;
        bit found = 1'b0;
        data_q.delete();
        data_q.push_back(8'($urandom));
        data_q.push_back(8'($urandom));
        make_packet(2, 1'b1, 1'b0);
        j = 2 + int'($urandom_range(1, 6));  // a SYNC symbol that follows a transition
        hold_q[j-1] = CPB + 2;
        hold_q[j]   = CPB - 2;
        got_q.delete();
        drive_seq(sym_q.size());
        run_model();
        foreach (got_q[i])
            if (got_q[i].kind == K_SHIFT && int'(got_q[i].cyc) == st_q[j] + LAT && got_q[i].val == 1'b0)
                found = 1'b1;
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL jitter_sample: got no 0-bit strobe at cycle %0d expected one", st_q[j] + LAT);
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL jitter_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL jitter_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        data_q.delete();
        data_q.push_back(8'h5A);
        make_packet(1, 1'b1, 1'b0);
        drive_seq(14);  // idle, SYNC and four data bits, then stop mid-byte
        rst = 1'b1;
        #1;
        vectors++;
        if ({d_original, shift_enable, byte_done, eop, stuff_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {d_original, shift_enable, byte_done, eop, stuff_err});
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        got_q.delete();
        repeat (30) @(posedge clk);
        #2;
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d pulses expected 0", got_q.size());
        end
        drive_seq(sym_q.size());
        run_model();
        vectors++;
        if (count_kind(K_BD) !== 2) begin
            miscompares++;
            $display("FAIL midreset_bytes: got %0d expected 2", count_kind(K_BD));
        end
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL midreset_events: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                         i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
    endtask

    task automatic test_rx_enable();
        data_q.delete();
        data_q.push_back(8'h3C);
        make_packet(1, 1'b1, 1'b0);
        rx_enable = 1'b0;
        got_q.delete();
        drive_seq(sym_q.size());
        vectors++;
        if (got_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rx_disabled: got %0d pulses expected 0", got_q.size());
        end
        rx_enable = 1'b1;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_random();
        int nb;
        for (int it = 0; it < 6; it++) begin
            nb = int'($urandom_range(1, 3));
            data_q.delete();
            for (int n = 0; n < nb; n++)
                data_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            make_packet(nb, 1'b1, 1'b0);
            got_q.delete();
            drive_seq(sym_q.size());
            run_model();
            vectors++;
            if (got_q.size() !== exp_q.size()) begin
                miscompares++;
                $display("FAIL rand%0d_events: got %0d expected %0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_ev%0d: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                             it, i, got_q[i].cyc, got_q[i].kind, got_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
                end
            end
        end
        vectors++;
        if (excl_viol !== 0) begin
            miscompares++;
            $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", excl_viol);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        rx_enable = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        test_reset();
        test_sync();
        test_stuffing();
        test_stuff_err();
        test_back_to_back();
        test_jitter();
        test_reset_mid_byte();
        test_rx_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
